// File: rtl/uart_crc_receiver_if.sv
// Serial line plus decoded-frame outputs of the CRC-protected UART receiver.
// The receiver takes the master side; the consumer takes the slave side.
interface uart_crc_receiver_if;
    logic       rx;
    logic [7:0] data_out;
    logic [3:0] crc_rx;
    logic       rx_valid;
    logic       crc_err;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data_out, crc_rx, rx_valid, crc_err, frame_err, busy
    );

    modport slave (
        output rx,
        input  data_out, crc_rx, rx_valid, crc_err, frame_err, busy
    );
endinterface

// File: rtl/uart_crc_receiver.sv
// UART receiver for 14-bit frames: start, 8 data LSB-first, 4 CRC LSB-first, stop.
// Recomputes CRC-4 (x^4+x+1) over the payload and reports CRC and framing errors.
module uart_crc_receiver #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_crc_receiver_if.master   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF  = (CLKS_PER_BIT + 1) / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, CRC, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_data_q, shift_data_d;
    logic [3:0]       shift_crc_q, shift_crc_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_prev_q, rx_prev_d;
    logic [1:0]       fill_q, fill_d;
    logic [7:0]       data_out_q, data_out_d;
    logic [3:0]       crc_rx_q, crc_rx_d;
    logic             rx_valid_q, rx_valid_d;
    logic             crc_err_q, crc_err_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    // Long division of {d, 4'b0000} by 5'b10011, MSB first.
    function automatic logic [3:0] crc4(input logic [7:0] d);
        logic [11:0] r;
        r = {d, 4'b0000};
        for (int i = 11; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_data_d = shift_data_q;
        shift_crc_d  = shift_crc_q;
        data_out_d   = data_out_q;
        crc_rx_d     = crc_rx_q;
        crc_err_d    = crc_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = 1'b0;

        rx_meta_d = bus.rx;
        rx_s_d    = rx_meta_q;
        // rx_prev only reports a real high once the synchronizer has refilled after
        // reset, so a line held low through reset never looks like a start edge.
        fill_d    = {fill_q[0], 1'b1};
        rx_prev_d = fill_q[1] & rx_s_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d               = '0;
                    shift_data_d[idx_q] = rx_s_q;
                    idx_d               = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = CRC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CRC: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d                   = '0;
                    shift_crc_d[idx_q[1:0]] = rx_s_q;
                    idx_d                   = idx_q + 3'd1;
                    if (idx_q == 3'd3) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    data_out_d  = shift_data_q;
                    crc_rx_d    = shift_crc_q;
                    crc_err_d   = (crc4(shift_data_q) != shift_crc_q);
                    frame_err_d = !rx_s_q;
                    rx_valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_data_q <= '0;
            shift_crc_q  <= '0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b0;
            fill_q       <= '0;
            data_out_q   <= '0;
            crc_rx_q     <= '0;
            rx_valid_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_data_q <= shift_data_d;
            shift_crc_q  <= shift_crc_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            fill_q       <= fill_d;
            data_out_q   <= data_out_d;
            crc_rx_q     <= crc_rx_d;
            rx_valid_q   <= rx_valid_d;
            crc_err_q    <= crc_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.crc_rx    = crc_rx_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_crc_receiver.sv
// Self-checking bench for uart_crc_receiver with CLKS_PER_BIT=15 (16-cycle bits).
// Directed frames plus random frames, checked against a serial CRC reference model.
module tb_uart_crc_receiver;

    localparam int CLKS      = 15;
    localparam int P         = CLKS + 1;
    localparam int H         = P / 2;
    localparam int FRAME_LAT = H + 13 * P;

    typedef struct {
        logic [7:0] data;
        logic [3:0] crc;
        logic       crc_err;
        logic       frame_err;
        int         cyc;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_crc_receiver_if bus ();

    uart_crc_receiver #(.CLKS_PER_BIT(CLKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     cyc = 0;
    int     n_pass = 0;
    int     n_checks = 0;
    frame_t got_q[$];
    frame_t exp_q[$];
    int     rise_q[$];
    int     fall_q[$];
    logic   busy_prev = 1'b0;
    frame_t mon_f;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every rx_valid cycle and every busy edge, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            mon_f.data      = bus.data_out;
            mon_f.crc       = bus.crc_rx;
            mon_f.crc_err   = bus.crc_err;
            mon_f.frame_err = bus.frame_err;
            mon_f.cyc       = cyc;
            got_q.push_back(mon_f);
        end
        if (bus.busy === 1'b1 && !busy_prev) rise_q.push_back(cyc);
        if (bus.busy !== 1'b1 && busy_prev) fall_q.push_back(cyc);
        busy_prev = (bus.busy === 1'b1);
    end

    // Reference CRC: bit-serial feedback register over the payload, MSB first.
    function automatic logic [3:0] model_crc(input logic [7:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 7; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic [3:0] c, input logic stop);
        frame_t f;
        f.data      = d;
        f.crc       = c;
        f.crc_err   = (c != model_crc(d));
        f.frame_err = !stop;
        f.cyc       = 0;
        exp_q.push_back(f);
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (P) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [3:0] c, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        for (int i = 0; i < 4; i++) send_bit(c[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        got_q.delete();
        exp_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic verify(input string tag);
        int n;
        check({tag, "/pulses"}, got_q.size(), exp_q.size());
        check({tag, "/busy_rises"}, rise_q.size(), exp_q.size());
        n = got_q.size();
        if (exp_q.size() < n) n = exp_q.size();
        if (rise_q.size() < n) n = rise_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s/data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s/crc%0d", tag, i), got_q[i].crc, exp_q[i].crc);
            check($sformatf("%s/crc_err%0d", tag, i), got_q[i].crc_err, exp_q[i].crc_err);
            check($sformatf("%s/frame_err%0d", tag, i), got_q[i].frame_err, exp_q[i].frame_err);
            check($sformatf("%s/latency%0d", tag, i), got_q[i].cyc - rise_q[i], FRAME_LAT);
            if (i < fall_q.size())
                check($sformatf("%s/busy_fall%0d", tag, i), fall_q[i], got_q[i].cyc);
        end
        flush();
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] c;
        logic       stop;

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset/data_out", bus.data_out, 8'h00);
        check("reset/crc_rx", bus.crc_rx, 4'h0);
        check("reset/rx_valid", bus.rx_valid, 1'b0);
        check("reset/crc_err", bus.crc_err, 1'b0);
        check("reset/frame_err", bus.frame_err, 1'b0);
        check("reset/busy", bus.busy, 1'b0);

        // Line held low through reset must not start a frame.
        bus.rx = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4 * P) @(negedge clk);
        check("held_low/no_start", rise_q.size(), 0);
        idle(2 * P);
        flush();

        expect_frame(8'hA5, 4'hB, 1'b1);
        send_frame(8'hA5, 4'hB, 1'b1);
        idle(2 * P);
        verify("a5");

        expect_frame(8'h00, 4'h0, 1'b1);
        expect_frame(8'hFF, 4'h4, 1'b1);
        send_frame(8'h00, 4'h0, 1'b1);
        send_frame(8'hFF, 4'h4, 1'b1);
        idle(2 * P);
        verify("b2b");

        expect_frame(8'hA5, 4'h3, 1'b1);
        send_frame(8'hA5, 4'h3, 1'b1);
        idle(2 * P);
        verify("badcrc");
        idle(3 * P);
        check("badcrc/hold", bus.crc_err, 1'b1);
        d = 8'($urandom);
        expect_frame(d, model_crc(d), 1'b1);
        send_frame(d, model_crc(d), 1'b1);
        idle(2 * P);
        verify("clear");

        expect_frame(8'h3C, model_crc(8'h3C), 1'b0);
        send_frame(8'h3C, model_crc(8'h3C), 1'b0);
        idle(2 * P);
        verify("stop0");

        // Four-cycle low glitch on an idle line.
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(2 * P);
        check("glitch/pulses", got_q.size(), 0);
        check("glitch/rises", rise_q.size(), 1);
        check("glitch/falls", fall_q.size(), 1);
        if (rise_q.size() == 1 && fall_q.size() == 1)
            check("glitch/busy_len", fall_q[0] - rise_q[0], H);
        flush();

        // Reset in the middle of the data bits, then a clean frame.
        fork
            send_frame(8'h5A, model_crc(8'h5A), 1'b1);
            begin
                repeat (3 * P) @(negedge clk);
                check("rst/busy_before", bus.busy, 1'b1);
                rst = 1'b1;
                @(negedge clk);
                check("rst/data_out", bus.data_out, 8'h00);
                check("rst/crc_rx", bus.crc_rx, 4'h0);
                check("rst/crc_err", bus.crc_err, 1'b0);
                check("rst/frame_err", bus.frame_err, 1'b0);
                check("rst/rx_valid", bus.rx_valid, 1'b0);
                check("rst/busy", bus.busy, 1'b0);
                repeat (12 * P) @(negedge clk);
            end
        join
        bus.rx = 1'b1;
        rst = 1'b0;
        idle(2 * P);
        check("rst/no_pulse", got_q.size(), 0);
        flush();
        expect_frame(8'h5A, model_crc(8'h5A), 1'b1);
        send_frame(8'h5A, model_crc(8'h5A), 1'b1);
        idle(2 * P);
        verify("after_rst");

        // Random frames with occasional CRC corruption, bad stop bits and gaps.
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            c = model_crc(d);
            if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
            stop = ($urandom_range(0, 3) != 0);
            expect_frame(d, c, stop);
            send_frame(d, c, stop);
            if (!stop || $urandom_range(0, 1) == 1) idle($urandom_range(2, 40));
        end
        idle(2 * P);
        verify("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_crc_receiver.md
# uart_crc_receiver

Serial receiver for the team's CRC-protected UART frame. It recovers the 8-bit payload and the 4-bit CRC from the line, then recomputes the CRC over the payload and flags any mismatch. It sits directly downstream of the UART CRC transmitter, on the far end of the serial link. It presents each frame to the consumer as a single-cycle valid pulse with error flags.

## Interface
- CLKS_PER_BIT, default 1042: bit period is CLKS_PER_BIT+1 clk cycles, matching the transmitter's 0..CLKS_PER_BIT count. 1042 gives 9600 baud at 10 MHz.
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- rx  input  1  asynchronous serial line, idle high
- data_out  output  8  last received payload; reset 8'h00
- crc_rx  output  4  last received CRC field; reset 4'h0
- rx_valid  output  1  one-cycle pulse, frame complete; reset 0
- crc_err  output  1  recomputed CRC differs from crc_rx; valid with rx_valid, held until the next frame; reset 0
- frame_err  output  1  stop bit sampled low; same validity as crc_err; reset 0
- busy  output  1  high whenever the state is not IDLE; reset 0

## Operation
- Frame format on the line, in order:
  - start bit (0)
  - data[0..7], LSB first
  - crc[0..3], LSB first
  - stop bit (1)
  - 14 bit periods total.
- CRC definition: remainder of {data, 4'b0000} divided by x^4+x+1 (5'b10011), MSB-first long division over bits 11..4. Results: 0x00 gives 0x0, 0xA5 gives 0xB, 0xFF gives 0x4.
- Synchronizer: rx passes through 2 flops (rx_s). Both flops reset to 1. A line held low through reset does not start a frame.
- States: IDLE, START, DATA, CRC, STOP.
- IDLE: on a falling edge of rx_s (previous 1, current 0), clear the counter and go to START.
- START: count to H = (CLKS_PER_BIT+1)/2 (integer division).
  - If rx_s is 1 at that sample, it was a glitch: return to IDLE with no outputs.
  - If rx_s is 0, clear the counter and the bit index, then go to DATA.
- DATA: sample rx_s every CLKS_PER_BIT+1 cycles into shift bit [index]. After the 8th sample, go to CRC with index 0.
- CRC: the same sampling scheme, 4 samples, then go to STOP.
- STOP: sample once after a full bit period. On the cycle after that sample:
  - data_out, crc_rx, crc_err and frame_err update
  - rx_valid pulses
  - the state returns to IDLE.
- The CRC is computed combinationally from the assembled data shift register and compared against the CRC shift register.
- A frame with frame_err still delivers data_out and crc_err.
- Counter width: $clog2(CLKS_PER_BIT+1) bits. The counter must never wrap inside a bit period.
- rst mid-frame: on the next cycle the state is IDLE and all outputs are at their reset values. The partial frame is discarded without an rx_valid pulse. A new frame is accepted only after rx_s has been seen high.

## Timing
- Let P = CLKS_PER_BIT+1 and let T0 be the cycle the IDLE edge detector fires. T0 is 3 cycles after the rx pin falls: 2 synchronizer cycles plus 1 edge cycle.
- Sample times:
  - start sample: T0+H
  - data bit k: T0+H+(k+1)P
  - CRC bit j: T0+H+(9+j)P
  - stop bit: T0+H+13P
- rx_valid is high for exactly the cycle T0+H+13P+1.
- IDLE is re-entered on that same cycle. A start edge arriving right after the stop bit's midpoint is accepted.
- The busy window runs from T0+1 through T0+H+13P inclusive.
- Worst-case tolerable sender/receiver bit-period mismatch: about ±3.5 % over 14 bits.

## Test plan
- Use CLKS_PER_BIT=15 (P=16). Drive frame 0xA5, CRC 0xB (line bits 1,1,0,1), stop 1. Expect one rx_valid pulse, data_out=8'hA5, crc_rx=4'hB, crc_err=0, frame_err=0. The pulse must land exactly at T0+8+208+1.
- Frames 0x00/CRC 0x0 and 0xFF/CRC 0x4 sent back-to-back with no idle gap. Expect two pulses, both error-free, with the second frame's start edge not lost.
- Frame 0xA5 with a corrupted CRC field 0x3. Expect data_out=8'hA5, crc_rx=4'h3, crc_err=1. The next clean frame clears crc_err to 0.
- Frame 0x3C with correct CRC but stop bit 0. Expect rx_valid, data_out=8'h3C, frame_err=1.
- Low glitch of 4 cycles on an idle line. Expect START then IDLE, no rx_valid, busy low again by T0+H+1.
- Assert rst during the DATA state of a 0x5A frame, then send a clean 0x5A frame. Expect outputs at reset values and no pulse for the aborted frame. The clean frame is then received correctly.
